i2c_regbank_slave: RTL and testbench

//  Parametrised I2C target with an NREGS x 8 register bank, the next generation of the dice-board I2C slave.

---
 rtl/i2c_regbank_slave.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_i2c_regbank_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regbank_slave.sv
`timescale 1ns/1ps
// i2c_regbank_slave
// I2C target with an NREGS x 8 register bank. After its 7-bit address, the
// controller sends a sub-address pointer, then reads or writes bytes. The
// pointer auto-increments and wraps modulo NREGS.
// Optional feature macro: I2C_READ_EN builds the controller-read path
// (RDATA/RDATA_ACK). Without it, a read address is NAKed.
module i2c_regbank_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  output logic [NREGS*8-1:0] regs_flat,
  output logic               wr_stb,
  output logic [PW-1:0]      wr_addr,
  output logic               busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t        state;
  state_t        state_n;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_cnt_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic [7:0]    shift_in;
  logic [PW-1:0] pointer;
  logic [PW-1:0] pointer_n;
  logic [PW-1:0] pointer_inc;
  logic          sda_oe_n;
  logic          busy_n;
  logic          wr_stb_n;
  logic [PW-1:0] wr_addr_n;
  logic          addr_match;
  logic          sub_in_range;
  logic          reg_we;
  logic [7:0]    regs [NREGS];
`ifdef I2C_READ_EN
  logic [7:0]    rd_byte;
`endif

  // Synchronise the pins, then keep one history flop of each for edge detection.
  // The history flops reset high (idle bus) so reset release creates no phantom START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign shift_in     = {shift[6:0], sda_s};
  assign pointer_inc  = (pointer == PW'(NREGS - 1)) ? '0 : pointer + PW'(1);
  assign sub_in_range = ({24'd0, shift} < 32'(NREGS));

`ifdef I2C_READ_EN
  assign addr_match = (shift[7:1] == I2C_ADDR);
  // Register writes happen on SCL rise and read loads on SCL fall, so a load
  // never coincides with a write. Any earlier write is already in the bank.
  assign rd_byte    = regs[pointer];
`else
  assign addr_match = (shift[7:1] == I2C_ADDR) && !shift[0];
`endif

  // Next-state and datapath decode. STOP/START override every state, and a low ena overrides everything.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    pointer_n = pointer;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    reg_we    = 1'b0;

    if (!ena) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (addr_match) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              state_n  = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
`ifdef I2C_READ_EN
            if (shift[0]) begin
              shift_n  = rd_byte;
              sda_oe_n = ~rd_byte[7];
              state_n  = RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = SUB;
            end
`else
            sda_oe_n = 1'b0;
            state_n  = SUB;
`endif
          end
        end

        SUB: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (sub_in_range) begin
              pointer_n = shift[PW-1:0];
              sda_oe_n  = 1'b1;
              state_n   = SUB_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end

        SUB_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end

        WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              reg_we    = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = pointer;
              pointer_n = pointer_inc;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = WDATA_ACK;
          end
        end

        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end

`ifdef I2C_READ_EN
        RDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n  = 1'b0;
            pointer_n = pointer_inc;
            state_n   = RDATA_ACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shift_n  = {shift[6:0], 1'b0};
            sda_oe_n = ~shift[6];
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            shift_n = shift_in;
          end else if (scl_fall) begin
            if (shift[0]) begin
              state_n = WAIT_STOP;
            end else begin
              bit_cnt_n = '0;
              shift_n   = rd_byte;
              sda_oe_n  = ~rd_byte[7];
              state_n   = RDATA;
            end
          end
        end
`endif

        WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // State and control registers; reset takes effect immediately, even mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      pointer <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      pointer <= pointer_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
    end
  end

  // Register bank: the completed byte is written at the current pointer on the 8th sampled bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[pointer] <= shift_in;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_regbank_slave.sv
`timescale 1ns/1ps
// tb_i2c_regbank_slave
// Directed bench for i2c_regbank_slave. It models an I2C controller and an SDA pull-up.
// Read expectations follow I2C_READ_EN as seen by the compile.
module tb_i2c_regbank_slave;

  localparam int Q = 2500;

`ifdef I2C_READ_EN
  localparam bit READ_BUILT = 1'b1;
`else
  localparam bit READ_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] addr_byte;
    logic [7:0] sub;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       addr_ack;
    logic       sub_ack;
    logic [1:0] exp_wr;
    logic [3:0] exp_wa0;
    logic [3:0] exp_wa1;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         scl = 1'b1;
  logic         sda_drv_low = 1'b0;
  logic         sda_line;
  logic         sda_oe;
  logic [127:0] regs_flat;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           wr_count = 0;
  int           oe_cycles = 0;
  logic [3:0]   wr_log [64];
  vec_t         vecs [5];

  assign sda_line = ~(sda_drv_low | sda_oe);

  i2c_regbank_slave #(
    .I2C_ADDR(7'h70),
    .NREGS(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .scl_in(scl),
    .sda_in(sda_line),
    .sda_oe(sda_oe),
    .regs_flat(regs_flat),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .busy(busy)
  );

  // 10 MHz system clock; posedges fall at odd multiples of 50 ns, clear of stimulus times
  always #50 clk = ~clk;

  // Log every write strobe with its index and count cycles in which SDA is pulled by the target
  always @(negedge clk) begin
    if (wr_stb) begin
      if (wr_count < 64) wr_log[wr_count] = wr_addr;
      wr_count++;
    end
    if (sda_oe) oe_cycles++;
  end

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0;
    scl = 1'b1;
    #Q;
    sda_drv_low = 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_restart();
    sda_drv_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    sda_drv_low = 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1;
    #Q;
    scl = 1'b1;
    #Q;
    sda_drv_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv_low = ~b;
    #Q;
    scl = 1'b1;
    #(2*Q);
    scl = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    sda_drv_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    ack = ~sda_line;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic recv_byte(input logic ack_out, output logic [7:0] data);
    data = '0;
    for (int i = 0; i < 8; i++) begin
      sda_drv_low = 1'b0;
      #Q;
      scl = 1'b1;
      #Q;
      data = {data[6:0], sda_line};
      #Q;
      scl = 1'b0;
      #Q;
    end
    sda_drv_low = ack_out;
    #Q;
    scl = 1'b1;
    #(2*Q);
    scl = 1'b0;
    #Q;
  endtask

  task automatic apply_stimulus(input vec_t v, output logic a_ack, output logic s_ack,
                                output logic [1:0] d_ack, output logic busy_mid);
    logic a0;
    logic a1;
    i2c_start();
    send_byte(v.addr_byte, a_ack);
    busy_mid = busy;
    send_byte(v.sub, s_ack);
    send_byte(v.d0, a0);
    send_byte(v.d1, a1);
    d_ack = {a1, a0};
    i2c_stop();
  endtask

  task automatic run_vector(input int idx);
    vec_t       v;
    int         wr_base;
    int         oe_base;
    logic       a_ack;
    logic       s_ack;
    logic [1:0] d_ack;
    logic       busy_mid;
    v = vecs[idx];
    wr_base = wr_count;
    oe_base = oe_cycles;
    apply_stimulus(v, a_ack, s_ack, d_ack, busy_mid);
    check_output($sformatf("vec%0d addr_ack", idx), 128'(a_ack), 128'(v.addr_ack));
    check_output($sformatf("vec%0d sub_ack", idx), 128'(s_ack), 128'(v.sub_ack));
    check_output($sformatf("vec%0d data_acks", idx), 128'(d_ack), 128'({2{v.sub_ack}}));
    check_output($sformatf("vec%0d busy_mid", idx), 128'(busy_mid), 128'(v.addr_ack));
    check_output($sformatf("vec%0d sda_oe_used", idx), 128'(oe_cycles != oe_base), 128'(v.addr_ack));
    check_output($sformatf("vec%0d wr_count", idx), 128'(wr_count - wr_base), 128'(v.exp_wr));
    if (v.exp_wr != 2'd0)
      check_output($sformatf("vec%0d wr_addr0", idx), 128'(wr_log[wr_base]), 128'(v.exp_wa0));
    if (v.exp_wr == 2'd2)
      check_output($sformatf("vec%0d wr_addr1", idx), 128'(wr_log[wr_base+1]), 128'(v.exp_wa1));
    check_output($sformatf("vec%0d busy_after_stop", idx), 128'(busy), 128'(0));
  endtask

  // Main directed sequence: reset state, write table, read-back, reset mid-transfer
  initial begin
    logic       a_ack;
    logic       s_ack;
    logic       r_ack;
    logic       ign;
    logic [7:0] b0;
    logic [7:0] b1;
    int         wr_base;

    vecs[0] = '{8'hE0, 8'h0A, 8'h55, 8'h1F, 1'b1, 1'b1, 2'd2, 4'd10, 4'd11};
    vecs[1] = '{8'hE0, 8'h0F, 8'hFA, 8'h4D, 1'b1, 1'b1, 2'd2, 4'd15, 4'd0};
    vecs[2] = '{8'hE2, 8'h03, 8'hAA, 8'h00, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0};
    vecs[3] = '{8'hE0, 8'h7F, 8'hAA, 8'h00, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};
    vecs[4] = '{8'hE0, 8'h02, 8'h99, 8'h66, 1'b1, 1'b1, 2'd2, 4'd2, 4'd3};

    rst_n = 1'b0;
    #1000;
    check_output("reset sda_oe", 128'(sda_oe), 128'(0));
    check_output("reset regs_flat", regs_flat, 128'(0));
    check_output("reset wr_stb", 128'(wr_stb), 128'(0));
    check_output("reset wr_addr", 128'(wr_addr), 128'(0));
    check_output("reset busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    #1000;

    for (int i = 0; i < 4; i++) run_vector(i);
    check_output("regs after writes", regs_flat, 128'hFA00_0000_1F55_0000_0000_0000_0000_004D);

    wr_base = wr_count;
    i2c_start();
    send_byte(8'hE0, a_ack);
    send_byte(8'h0A, s_ack);
    i2c_restart();
    send_byte(8'hE1, r_ack);
    check_output("read busy", 128'(busy), 128'(1));
    recv_byte(1'b1, b0);
    recv_byte(1'b0, b1);
    i2c_stop();
    check_output("read addr_w_ack", 128'(a_ack), 128'(1));
    check_output("read sub_ack", 128'(s_ack), 128'(1));
    check_output("read addr_r_ack", 128'(r_ack), 128'(READ_BUILT));
    check_output("read byte0", 128'(b0), 128'(READ_BUILT ? 8'h55 : 8'hFF));
    check_output("read byte1", 128'(b1), 128'(READ_BUILT ? 8'h1F : 8'hFF));
    check_output("read busy_after_stop", 128'(busy), 128'(0));
    check_output("read no writes", 128'(wr_count - wr_base), 128'(0));
    check_output("regs after read", regs_flat, 128'hFA00_0000_1F55_0000_0000_0000_0000_004D);

    i2c_start();
    send_byte(8'hE0, a_ack);
    send_byte(8'h02, ign);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    sda_drv_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    check_output("pre-reset busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #Q;
    check_output("midreset sda_oe", 128'(sda_oe), 128'(0));
    check_output("midreset regs_flat", regs_flat, 128'(0));
    check_output("midreset busy", 128'(busy), 128'(0));
    check_output("midreset wr_stb", 128'(wr_stb), 128'(0));
    scl = 1'b0;
    #Q;
    rst_n = 1'b1;
    #Q;
    i2c_stop();

    run_vector(4);
    check_output("regs after reset write", regs_flat, 128'h0000_0000_0000_0000_0000_0000_6699_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
